// File: rtl/cmp_arb_pkg.sv
// Shared encodings for the compare-core arbiter: FSM states and compare opcodes.
package cmp_arb_pkg;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_CALC = 2'd1;
   localparam logic [1:0] ST_RESP = 2'd2;

   localparam logic OP_SLT  = 1'b0;
   localparam logic OP_SLTU = 1'b1;

endpackage

// File: rtl/cmp_core.sv
// Combinational set-less-than core: lt = (a < b), signed or unsigned by op.
module cmp_core
   import cmp_arb_pkg::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input  logic             op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             lt
);

   always_comb begin
      if (op == OP_SLTU) lt = (a < b);
      else               lt = ($signed(a) < $signed(b));
   end

endmodule

// File: rtl/cmp_arbiter.sv
// Two-port round-robin front end for one shared compare core (IDLE -> CALC -> RESP).
// Optional grant counters are enabled by defining CMP_ARB_STATS_EN.
module cmp_arbiter
   import cmp_arb_pkg::*;
#(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned ID_W  = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             r0_valid,
   output logic             r0_ready,
   input  logic             r0_op,
   input  logic [WIDTH-1:0] r0_a,
   input  logic [WIDTH-1:0] r0_b,
   input  logic             r1_valid,
   output logic             r1_ready,
   input  logic             r1_op,
   input  logic [WIDTH-1:0] r1_a,
   input  logic [WIDTH-1:0] r1_b,
`ifdef CMP_ARB_STATS_EN
   output logic [15:0]      gnt0_cnt,
   output logic [15:0]      gnt1_cnt,
`endif
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [ID_W-1:0]  rsp_id,
   output logic [WIDTH-1:0] rsp_data
);

   logic [1:0]       state_q, state_d;
   logic             last_grant_q;
   logic             op_q;
   logic [WIDTH-1:0] a_q, b_q;
   logic             id_q;
   logic             rsp_valid_q;
   logic [ID_W-1:0]  rsp_id_q;
   logic [WIDTH-1:0] rsp_data_q;

   logic pick0, pick1, in_idle, accept, lt;

   // r0 wins a tie only when r1 was the last one served
   always_comb begin
      pick0    = r0_valid && (!r1_valid || last_grant_q);
      pick1    = r1_valid && !pick0;
      in_idle  = (state_q == ST_IDLE) && !rst;
      r0_ready = in_idle && pick0;
      r1_ready = in_idle && pick1;
      accept   = r0_ready || r1_ready;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (accept) state_d = ST_CALC;
         ST_CALC: state_d = ST_RESP;
         ST_RESP: if (rsp_ready) state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   cmp_core #(
      .WIDTH(WIDTH)
   ) u_cmp_core (
      .op(op_q),
      .a (a_q),
      .b (b_q),
      .lt(lt)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         last_grant_q <= 1'b1;
         op_q         <= OP_SLT;
         a_q          <= '0;
         b_q          <= '0;
         id_q         <= 1'b0;
         rsp_valid_q  <= 1'b0;
         rsp_id_q     <= '0;
         rsp_data_q   <= '0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            op_q         <= pick1 ? r1_op : r0_op;
            a_q          <= pick1 ? r1_a  : r0_a;
            b_q          <= pick1 ? r1_b  : r0_b;
            id_q         <= pick1;
            last_grant_q <= pick1;
         end
         if (state_q == ST_CALC) begin
            rsp_data_q  <= WIDTH'(lt);
            rsp_id_q    <= ID_W'(id_q);
            rsp_valid_q <= 1'b1;
         end
         if ((state_q == ST_RESP) && rsp_ready) rsp_valid_q <= 1'b0;
      end
   end

   assign rsp_valid = rsp_valid_q;
   assign rsp_id    = rsp_id_q;
   assign rsp_data  = rsp_data_q;

`ifdef CMP_ARB_STATS_EN
   logic [15:0] gnt0_cnt_q, gnt1_cnt_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         gnt0_cnt_q <= '0;
         gnt1_cnt_q <= '0;
      end else begin
         if (r0_ready) gnt0_cnt_q <= gnt0_cnt_q + 16'd1;
         if (r1_ready) gnt1_cnt_q <= gnt1_cnt_q + 16'd1;
      end
   end

   assign gnt0_cnt = gnt0_cnt_q;
   assign gnt1_cnt = gnt1_cnt_q;
`endif

endmodule

// File: tb/tb_cmp_arbiter.sv
// Self-checking bench for cmp_arbiter: table vectors, corner sequences, random vs model.
module tb_cmp_arbiter;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        r0_valid = 1'b0, r0_op = 1'b0;
   logic [31:0] r0_a = '0, r0_b = '0;
   logic        r1_valid = 1'b0, r1_op = 1'b0;
   logic [31:0] r1_a = '0, r1_b = '0;
   logic        r0_ready, r1_ready;
   logic        rsp_valid;
   logic        rsp_ready = 1'b1;
   logic [0:0]  rsp_id;
   logic [31:0] rsp_data;
`ifdef CMP_ARB_STATS_EN
   logic [15:0] gnt0_cnt, gnt1_cnt;
`endif

   always #5 clk = ~clk;

   cmp_arbiter #(
      .WIDTH(32),
      .ID_W (1)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .r0_valid (r0_valid),
      .r0_ready (r0_ready),
      .r0_op    (r0_op),
      .r0_a     (r0_a),
      .r0_b     (r0_b),
      .r1_valid (r1_valid),
      .r1_ready (r1_ready),
      .r1_op    (r1_op),
      .r1_a     (r1_a),
      .r1_b     (r1_b),
`ifdef CMP_ARB_STATS_EN
      .gnt0_cnt (gnt0_cnt),
      .gnt1_cnt (gnt1_cnt),
`endif
      .rsp_valid(rsp_valid),
      .rsp_ready(rsp_ready),
      .rsp_id   (rsp_id),
      .rsp_data (rsp_data)
   );

   int n_cmp = 0;
   int n_err = 0;

   // Transaction-level reference: at most one job in flight, either computing or offered.
   bit          m_job, m_calc, m_last, m_job_id, m_job_res, m_out_id;
   logic [31:0] m_out_data;

   typedef struct {
      bit          req;
      bit          op;
      logic [31:0] a;
      logic [31:0] b;
      bit          exp;
   } vec_t;

   vec_t vecs[10];

   function automatic bit ref_lt(bit op, logic [31:0] a, logic [31:0] b);
      // Signed order equals unsigned order once the sign bits are flipped.
      if (op) return a < b;
      return (a ^ 32'h8000_0000) < (b ^ 32'h8000_0000);
   endfunction

   function automatic bit ref_pick();
      if (r0_valid && r1_valid) return !m_last;
      return r1_valid;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   task automatic model_reset();
      m_job = 0; m_calc = 0; m_last = 1; m_job_id = 0; m_job_res = 0;
      m_out_id = 0; m_out_data = '0;
   endtask

   task automatic settle_and_check();
      bit any, g;
      #1;
      any = !rst && !m_job && (r0_valid || r1_valid);
      g   = ref_pick();
      check("r0_ready", r0_ready, any && !g);
      check("r1_ready", r1_ready, any && g);
      check("rsp_valid", rsp_valid, m_job && !m_calc);
      check("rsp_id", rsp_id, m_out_id);
      check("rsp_data", rsp_data, m_out_data);
   endtask

   task automatic advance();
      bit g;
      @(posedge clk);
      if (!rst) begin
         if (!m_job) begin
            if (r0_valid || r1_valid) begin
               g         = ref_pick();
               m_job     = 1;
               m_calc    = 1;
               m_job_id  = g;
               m_job_res = g ? ref_lt(r1_op, r1_a, r1_b) : ref_lt(r0_op, r0_a, r0_b);
               m_last    = g;
            end
         end else if (m_calc) begin
            m_calc     = 0;
            m_out_id   = m_job_id;
            m_out_data = {31'b0, m_job_res};
         end else if (rsp_ready) begin
            m_job = 0;
         end
      end
      @(negedge clk);
   endtask

   task automatic step();
      settle_and_check();
      advance();
   endtask

   task automatic do_reset();
      rst = 1; r0_valid = 1; r1_valid = 1;
      model_reset();
      #1;
      check("rst_r0_ready", r0_ready, 0);
      check("rst_r1_ready", r1_ready, 0);
      check("rst_rsp_valid", rsp_valid, 0);
      check("rst_rsp_id", rsp_id, 0);
      check("rst_rsp_data", rsp_data, 0);
      @(posedge clk);
      @(negedge clk);
      rst = 0; r0_valid = 0; r1_valid = 0;
   endtask

   task automatic run_vec(input vec_t v);
      r0_valid = !v.req; r0_op = v.op; r0_a = v.a; r0_b = v.b;
      r1_valid = v.req;  r1_op = v.op; r1_a = v.a; r1_b = v.b;
      rsp_ready = 1;
      settle_and_check();
      check("vec_accept", v.req ? r1_ready : r0_ready, 1);
      advance();
      r0_valid = 0; r1_valid = 0;
      settle_and_check();
      check("vec_calc_novalid", rsp_valid, 0);
      advance();
      settle_and_check();
      check("vec_latency", rsp_valid, 1);
      check("vec_data", rsp_data, {31'b0, v.exp});
      check("vec_id", rsp_id, v.req);
      advance();
   endtask

   initial begin
      #500000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1);
   end

   initial begin
      bit          exp_g;
      int          grants;
      logic [31:0] held_data;
      logic [0:0]  held_id;

      vecs[0] = '{0, 1, 32'h0000_0000, 32'hFFFF_FFFF, 1};
      vecs[1] = '{1, 0, 32'hFFFF_FFFF, 32'h0F80_0000, 1};
      vecs[2] = '{1, 1, 32'hFFFF_FFFF, 32'h0F80_0000, 0};
      vecs[3] = '{0, 1, 32'h8004_0003, 32'h0000_000F, 0};
      vecs[4] = '{0, 0, 32'h8004_0003, 32'h0000_000F, 1};
      vecs[5] = '{0, 0, 32'h0000_0005, 32'h0000_0005, 0};
      vecs[6] = '{1, 1, 32'h0000_0007, 32'h0000_0007, 0};
      vecs[7] = '{0, 0, 32'h7FFF_FFFF, 32'h8000_0000, 0};
      vecs[8] = '{1, 0, 32'h8000_0000, 32'h7FFF_FFFF, 1};
      vecs[9] = '{0, 1, 32'h7FFF_FFFF, 32'h8000_0000, 1};

      @(negedge clk);
      do_reset();
      for (int i = 0; i < 10; i++) run_vec(vecs[i]);

      // Both requesters always valid: grants must alternate starting with r0.
      do_reset();
      r0_valid = 1; r1_valid = 1; rsp_ready = 1;
      r0_a = 32'd1; r0_b = 32'd2; r1_a = 32'd9; r1_b = 32'd3;
      exp_g = 0; grants = 0;
      for (int i = 0; i < 14; i++) begin
         settle_and_check();
         check("one_hot_ready", r0_ready & r1_ready, 0);
         if (r0_ready || r1_ready) begin
            check("alt_grant", r1_ready, exp_g);
            exp_g = !exp_g;
            grants++;
         end
         if (rsp_valid) check("alt_rsp_id", rsp_id, !exp_g);
         advance();
      end
      check("alt_grant_count", grants >= 4, 1);

      // Back-pressure: response held for 5 cycles with both requesters waiting.
      rsp_ready = 0;
      for (int i = 0; i < 6 && !(m_job && !m_calc); i++) step();
      check("bp_reached_resp", m_job && !m_calc, 1);
      held_data = m_out_data; held_id = m_out_id;
      for (int i = 0; i < 5; i++) begin
         settle_and_check();
         check("bp_valid", rsp_valid, 1);
         check("bp_data", rsp_data, held_data);
         check("bp_id", rsp_id, held_id);
         check("bp_readies", {r0_ready, r1_ready}, 0);
         advance();
      end
      rsp_ready = 1;
      step();

      // Reset during CALC discards the captured request.
      do_reset();
      r0_valid = 1; r0_op = 1; r0_a = 32'd0; r0_b = 32'd1;
      step();
      r0_valid = 0;
      settle_and_check();
      rst = 1;
      model_reset();
      #1;
      check("midrst_rsp_valid", rsp_valid, 0);
      check("midrst_rsp_data", rsp_data, 0);
      check("midrst_rsp_id", rsp_id, 0);
      @(posedge clk);
      @(negedge clk);
      rst = 0;
      for (int i = 0; i < 3; i++) begin
         settle_and_check();
         check("midrst_no_rsp", rsp_valid, 0);
         advance();
      end
      r0_valid = 1; r1_valid = 1;
      settle_and_check();
      check("midrst_tie_r0", r0_ready, 1);
      advance();
      r0_valid = 0; r1_valid = 0;
      for (int i = 0; i < 3; i++) step();

      // Random traffic, operands changing freely while not granted.
      for (int i = 0; i < 600; i++) begin
         r0_valid  = ($urandom_range(0, 3) != 0);
         r1_valid  = ($urandom_range(0, 2) != 0);
         r0_op     = $urandom_range(0, 1);
         r1_op     = $urandom_range(0, 1);
         r0_a      = $urandom;
         r1_a      = $urandom;
         r0_b      = ($urandom_range(0, 7) == 0) ? r0_a : $urandom;
         r1_b      = ($urandom_range(0, 7) == 0) ? r1_a : ($urandom & 32'h8000_00FF);
         rsp_ready = ($urandom_range(0, 9) < 7);
         step();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
